// File: rtl/comparador_serial.sv
// Bit-serial LSB-first unsigned magnitude comparator.
// One comparator cell per clock; reports A > B and A == B.
module comparador_serial #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         W_out,
    output logic         W_eq,
    output logic         busy
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           gt_q, gt_d;
    logic           eq_q, eq_d;
    logic           wout_q, wout_d;
    logic           weq_q, weq_d;
    logic           bit_ne;
    logic           gt_nx;
    logic           eq_nx;

    // Same right-to-left cell as the parallel network: a higher
    // differing bit overrides whatever the lower bits decided.
    assign bit_ne = a_q[0] ^ b_q[0];
    assign gt_nx  = (a_q[0] & ~b_q[0]) | (~bit_ne & gt_q);
    assign eq_nx  = eq_q & ~bit_ne;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        wout_d  = wout_q;
        weq_d   = weq_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                gt_d  = gt_nx;
                eq_d  = eq_nx;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    wout_d  = gt_nx;
                    weq_d   = eq_nx;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            wout_q  <= 1'b0;
            weq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            wout_q  <= wout_d;
            weq_q   <= weq_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign W_out     = wout_q;
    assign W_eq      = weq_q;

endmodule

// File: tb/tb_comparador_serial.sv
// Self-checking bench for comparador_serial (N=4, N=1, N=8 instances).
// Expected results come from plain unsigned arithmetic.
module tb_comparador_serial;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       iv4 = 0, ir4, ov4, or4 = 0, wo4, we4, bz4;
    logic [3:0] A4 = 0, B4 = 0;
    logic       iv1 = 0, ir1, ov1, or1 = 0, wo1, we1, bz1;
    logic [0:0] A1 = 0, B1 = 0;
    logic       iv8 = 0, ir8, ov8, or8 = 0, wo8, we8, bz8;
    logic [7:0] A8 = 0, B8 = 0;

    comparador_serial #(.N(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .A(A4), .B(B4), .out_valid(ov4), .out_ready(or4),
        .W_out(wo4), .W_eq(we4), .busy(bz4)
    );
    comparador_serial #(.N(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
        .A(A1), .B(B1), .out_valid(ov1), .out_ready(or1),
        .W_out(wo1), .W_eq(we1), .busy(bz1)
    );
    comparador_serial #(.N(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .A(A8), .B(B8), .out_valid(ov8), .out_ready(or8),
        .W_out(wo8), .W_eq(we8), .busy(bz8)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs are scrambled after accept; hold = cycles of backpressure.
    task automatic op4(input logic [3:0] a, input logic [3:0] b,
                       input int hold, input string tag);
        int lat = 0;
        logic egt = (a > b);
        logic eeq = (a == b);
        chk({tag, "_in_ready"}, 32'(ir4), 1);
        iv4 = 1; A4 = a; B4 = b;
        tick();
        iv4 = 0;
        chk({tag, "_busy"}, 32'(bz4), 1);
        while (!ov4 && lat < 20) begin
            A4 = 4'($urandom); B4 = 4'($urandom);
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 4);
        chk({tag, "_gt"}, 32'(wo4), 32'(egt));
        chk({tag, "_eq"}, 32'(we4), 32'(eeq));
        for (int i = 0; i < hold; i++) begin
            iv4 = 1; A4 = 4'($urandom); B4 = 4'($urandom);
            tick();
            iv4 = 0;
            chk({tag, "_hold_valid"}, 32'(ov4), 1);
            chk({tag, "_hold_gt"}, 32'(wo4), 32'(egt));
            chk({tag, "_hold_eq"}, 32'(we4), 32'(eeq));
            chk({tag, "_hold_ready"}, 32'(ir4), 0);
        end
        or4 = 1;
        tick();
        or4 = 0;
        chk({tag, "_consumed"}, 32'(ov4), 0);
        chk({tag, "_idle"}, 32'(ir4), 1);
        chk({tag, "_kept_gt"}, 32'(wo4), 32'(egt));
    endtask

    task automatic op1(input logic a, input logic b, input string tag);
        int lat = 0;
        iv1 = 1; A1 = a; B1 = b;
        tick();
        iv1 = 0;
        while (!ov1 && lat < 10) begin
            A1 = ~A1; B1 = ~B1;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 1);
        chk({tag, "_gt"}, 32'(wo1), 32'(a > b));
        chk({tag, "_eq"}, 32'(we1), 32'(a == b));
        or1 = 1;
        tick();
        or1 = 0;
        chk({tag, "_idle"}, 32'(ir1), 1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        int lat = 0;
        int guard = 0;
        bit done = 0;
        bit r;
        iv8 = 1; A8 = a; B8 = b;
        tick();
        iv8 = 0;
        while (!ov8 && lat < 30) begin
            A8 = 8'($urandom); B8 = 8'($urandom);
            tick();
            lat++;
        end
        chk("rnd_latency", 32'(lat), 8);
        chk("rnd_gt", 32'(wo8), 32'(a > b));
        chk("rnd_eq", 32'(we8), 32'(a == b));
        while (!done && guard < 50) begin
            r = 1'($urandom_range(0, 1));
            or8 = r;
            tick();
            if (r) done = 1;
            guard++;
        end
        or8 = 0;
        chk("rnd_consumed", 32'(ov8), 0);
    endtask

    initial begin
        int seen;
        #2;
        chk("rst_in_ready", 32'(ir4), 1);
        chk("rst_out_valid", 32'(ov4), 0);
        chk("rst_w_out", 32'(wo4), 0);
        chk("rst_w_eq", 32'(we4), 0);
        chk("rst_busy", 32'(bz4), 0);
        tick();
        rst_n = 1;
        tick();

        op4(4'b1010, 4'b0110, 0, "basic_gt");
        op4(4'b0011, 4'b1000, 0, "basic_lt");
        op4(4'b0101, 4'b0101, 0, "equal");
        op4(4'b0001, 4'b0000, 0, "lsb_gt");
        op4(4'b1000, 4'b0111, 0, "msb_over");
        op4(4'b1100, 4'b1011, 0, "stability");
        op4(4'b0110, 4'b0010, 3, "backpressure");
        chk("bp_not_busy", 32'(bz4), 0);

        iv4 = 1; A4 = 4'b1010; B4 = 4'b0110;
        tick();
        iv4 = 0;
        tick();
        tick();
        rst_n = 0;
        #1;
        chk("mid_rst_ready", 32'(ir4), 1);
        chk("mid_rst_busy", 32'(bz4), 0);
        chk("mid_rst_valid", 32'(ov4), 0);
        chk("mid_rst_w_out", 32'(wo4), 0);
        chk("mid_rst_w_eq", 32'(we4), 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ov4) seen++;
        end
        chk("mid_rst_no_valid", 32'(seen), 0);
        rst_n = 1;
        tick();
        op4(4'b0111, 4'b0111, 0, "after_rst");

        op1(1'b1, 1'b0, "n1_10");
        op1(1'b0, 1'b1, "n1_01");
        op1(1'b0, 1'b0, "n1_00");
        op1(1'b1, 1'b1, "n1_11");

        for (int i = 0; i < 8; i++)
            op4(4'($urandom), 4'($urandom), i % 2, "rnd4");

        for (int i = 0; i < 1000; i++) begin
            logic [7:0] a, b;
            a = 8'($urandom);
            b = (i % 7 == 0) ? a : 8'($urandom);
            op8(a, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
